// File: rtl/match_req_initiator.sv
// match_req_initiator
//   Job-PE-side initiator for the match request/response protocol.
//   Accepts one job (head address + up to NUM_CAND candidate history
//   addresses with a valid mask), issues one match request per valid
//   candidate (lowest index first), collects the possibly out-of-order
//   responses and returns the longest match with its history address.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_job_*/o_job_ready         job handshake (head, histories, cand mask)
//   o_match_req_*/i_match_req_ready    request channel, tag = {seq, cand_idx}
//   i_match_resp_*/o_match_resp_ready  response channel (pe id, tag, len)
//   o_result_*/i_result_ready   best length, history address, cand index

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 5
`endif
`ifndef MAX_MATCH_LEN
`define MAX_MATCH_LEN 32
`endif

// Per-candidate bookkeeping: pending (not yet issued) and outstanding
// (issued, response not yet consumed). Issue and consume never target the
// same slot in one cycle: a slot is pending or outstanding, never both.
module match_cand_slot (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_bit,
    input  logic issue,
    input  logic consume,
    output logic pending,
    output logic outstanding
);
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            outstanding <= 1'b0;
        end else if (load) begin
            pending     <= load_bit;
            outstanding <= 1'b0;
        end else begin
            if (issue) begin
                pending     <= 1'b0;
                outstanding <= 1'b1;
            end
            if (consume) outstanding <= 1'b0;
        end
    end
endmodule

module match_req_initiator #(
    parameter int JOB_PE_IDX = 0,
    parameter int NUM_CAND   = 4,
    parameter int CAND_IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_job_valid,
    output logic                               o_job_ready,
    input  logic [`ADDR_WIDTH-1:0]             i_job_head_addr,
    input  logic [NUM_CAND*`ADDR_WIDTH-1:0]    i_job_history_addr,
    input  logic [NUM_CAND-1:0]                i_job_cand_mask,
    output logic                               o_match_req_valid,
    input  logic                               i_match_req_ready,
    output logic [`NUM_JOB_PE_LOG2-1:0]        o_match_req_job_pe_id,
    output logic [7:0]                         o_match_req_tag,
    output logic [`ADDR_WIDTH-1:0]             o_match_req_head_addr,
    output logic [`ADDR_WIDTH-1:0]             o_match_req_history_addr,
    input  logic                               i_match_resp_valid,
    output logic                               o_match_resp_ready,
    input  logic [`NUM_JOB_PE_LOG2-1:0]        i_match_resp_job_pe_id,
    input  logic [7:0]                         i_match_resp_tag,
    input  logic [`MAX_MATCH_LEN_LOG2:0]       i_match_resp_match_len,
    output logic                               o_result_valid,
    input  logic                               i_result_ready,
    output logic [`MAX_MATCH_LEN_LOG2:0]       o_result_match_len,
    output logic [`ADDR_WIDTH-1:0]             o_result_history_addr,
    output logic [CAND_IDX_W-1:0]              o_result_cand_idx
);
    localparam int AW = `ADDR_WIDTH;
    localparam int PW = `NUM_JOB_PE_LOG2;
    localparam int LW = `MAX_MATCH_LEN_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT, S_DONE} state_t;

    typedef struct packed {
        logic [PW-1:0] pe;
        logic [3:0]    seq;
        logic [3:0]    idx;
        logic [LW-1:0] len;
    } resp_t;

    state_t                       state;
    logic [3:0]                   seq;
    logic [AW-1:0]                head_q;
    logic [NUM_CAND-1:0][AW-1:0]  hist_q;
    logic [LW-1:0]                best_len;
    logic [CAND_IDX_W-1:0]        best_idx;
    logic [AW-1:0]                best_addr;
    logic                         have_best;

    logic [NUM_CAND-1:0]          pending, outstanding, issue_oh, consume_oh;
    logic [NUM_CAND-1:0]          pending_nxt;
    logic [CAND_IDX_W-1:0]        issue_idx, resp_cidx;
    logic [15:0]                  outstanding16;
    logic                         job_hs, req_hs, resp_hs, resp_hit, better;
    resp_t                        rsp;

    assign job_hs  = o_job_ready & i_job_valid;
    assign req_hs  = o_match_req_valid & i_match_req_ready;
    assign resp_hs = o_match_resp_ready & i_match_resp_valid;

    assign rsp = '{pe: i_match_resp_job_pe_id, seq: i_match_resp_tag[7:4],
                   idx: i_match_resp_tag[3:0], len: i_match_resp_match_len};

    // Lowest set pending bit is the candidate being offered.
    always_comb begin
        issue_idx = '0;
        for (int c = NUM_CAND - 1; c >= 0; c--)
            if (pending[c]) issue_idx = CAND_IDX_W'(c);
    end

    // Zero-extend so any 4-bit tag index can be looked up safely; indices
    // at or beyond NUM_CAND read as not outstanding.
    assign outstanding16 = 16'(outstanding);
    assign resp_cidx     = CAND_IDX_W'(rsp.idx);
    assign resp_hit      = resp_hs && (rsp.pe == PW'(JOB_PE_IDX)) && (rsp.seq == seq)
                        && ({1'b0, rsp.idx} < 5'(NUM_CAND)) && outstanding16[rsp.idx];

    assign better = !have_best || (rsp.len > best_len)
                 || ((rsp.len == best_len) && (resp_cidx < best_idx));

    assign pending_nxt = pending & ~issue_oh;

    genvar c;
    generate
        for (c = 0; c < NUM_CAND; c++) begin : g_cand
            assign issue_oh[c]   = req_hs && pending[c] && (issue_idx == CAND_IDX_W'(c));
            assign consume_oh[c] = resp_hit && (rsp.idx == 4'(c));
            match_cand_slot u_slot (
                .clk         (clk),
                .rst         (rst),
                .load        (job_hs),
                .load_bit    (i_job_cand_mask[c]),
                .issue       (issue_oh[c]),
                .consume     (consume_oh[c]),
                .pending     (pending[c]),
                .outstanding (outstanding[c])
            );
        end
    endgenerate

    assign o_match_req_job_pe_id    = PW'(JOB_PE_IDX);
    assign o_match_req_tag          = {seq, 4'(issue_idx)};
    assign o_match_req_head_addr    = head_q;
    assign o_match_req_history_addr = hist_q[issue_idx];
    assign o_result_match_len       = best_len;
    assign o_result_cand_idx        = best_idx;
    assign o_result_history_addr    = best_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            seq                <= '0;
            head_q             <= '0;
            hist_q             <= '0;
            best_len           <= '0;
            best_idx           <= '0;
            best_addr          <= '0;
            have_best          <= 1'b0;
            o_job_ready        <= 1'b1;
            o_match_req_valid  <= 1'b0;
            o_match_resp_ready <= 1'b0;
            o_result_valid     <= 1'b0;
        end else begin
            // Only reachable in ISSUE/COLLECT, where resp_ready is high.
            if (resp_hit && better) begin
                best_len  <= rsp.len;
                best_idx  <= resp_cidx;
                best_addr <= hist_q[resp_cidx];
                have_best <= 1'b1;
            end
            case (state)
                S_IDLE: if (job_hs) begin
                    head_q      <= i_job_head_addr;
                    hist_q      <= i_job_history_addr;
                    best_len    <= '0;
                    best_idx    <= '0;
                    best_addr   <= '0;
                    have_best   <= 1'b0;
                    o_job_ready <= 1'b0;
                    if (i_job_cand_mask == '0) begin
                        state          <= S_DONE;
                        o_result_valid <= 1'b1;
                    end else begin
                        state              <= S_ISSUE;
                        o_match_req_valid  <= 1'b1;
                        o_match_resp_ready <= 1'b1;
                    end
                end
                S_ISSUE: if (req_hs && (pending_nxt == '0)) begin
                    state             <= S_COLLECT;
                    o_match_req_valid <= 1'b0;
                end
                // Registered check: DONE follows the cycle in which the
                // last outstanding bit reads as cleared.
                S_COLLECT: if (outstanding == '0) begin
                    state              <= S_DONE;
                    o_match_resp_ready <= 1'b0;
                    o_result_valid     <= 1'b1;
                end
                S_DONE: if (i_result_ready) begin
                    state          <= S_IDLE;
                    o_result_valid <= 1'b0;
                    o_job_ready    <= 1'b1;
                    seq            <= seq + 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
